// File: rtl/alu_decode_stage.sv
// Single-stage decoder: turns a 16-bit instruction into registered ALU control signals.
// Outputs hold on stall; flush and reset squash the stage to NOP.
module alu_decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  input  logic        stall,
  input  logic        flush,
  output logic        in_ready,
  output logic        out_valid,
  output logic [2:0]  Op,
  output logic        Cin,
  output logic        invA,
  output logic        invB,
  output logic        sign,
  output logic [1:0]  comp_cont,
  output logic        comp,
  output logic        pass,
  output logic        ex_BTR,
  output logic        ex_SLBI,
  output logic        imm_sel,
  output logic        illegal
);

  localparam int unsigned OPC_W  = 5;
  localparam int unsigned FUNC_W = 2;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned CC_W   = 2;

  localparam logic [OP_W-1:0] OP_ADD = 3'b100;
  localparam logic [OP_W-1:0] OP_XOR = 3'b110;
  localparam logic [OP_W-1:0] OP_AND = 3'b111;

  logic [OPC_W-1:0]  w_opcode;
  logic [FUNC_W-1:0] w_func;
  logic              w_unused;

  assign w_opcode = in_instr[15:11];
  assign w_func   = in_instr[1:0];
  assign w_unused = ^in_instr[10:2];
  assign in_ready = !stall;

  logic [OP_W-1:0] w_op;
  logic            w_cin, w_inva, w_invb, w_sign;
  logic [CC_W-1:0] w_cc;
  logic            w_comp, w_pass, w_btr, w_slbi, w_imm, w_illegal;

  // Combinational decode of the incoming instruction
  always_comb begin
    w_op      = '0;
    w_cin     = 1'b0;
    w_inva    = 1'b0;
    w_invb    = 1'b0;
    w_cc      = '0;
    w_comp    = 1'b0;
    w_pass    = 1'b0;
    w_btr     = 1'b0;
    w_slbi    = 1'b0;
    w_imm     = 1'b0;
    w_illegal = 1'b0;
    case (w_opcode)
      5'b01000, 5'b10000, 5'b10001, 5'b10011: begin
        w_op  = OP_ADD;
        w_imm = 1'b1;
      end
      5'b01001: begin
        w_op   = OP_ADD;
        w_inva = 1'b1;
        w_cin  = 1'b1;
        w_imm  = 1'b1;
      end
      5'b01010: begin
        w_op  = OP_XOR;
        w_imm = 1'b1;
      end
      5'b01011: begin
        w_op   = OP_AND;
        w_invb = 1'b1;
        w_imm  = 1'b1;
      end
      5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
        w_op  = OP_W'({1'b0, w_opcode[1:0]});
        w_imm = 1'b1;
      end
      5'b11010: w_op = OP_W'({1'b0, w_func});
      5'b11011: begin
        case (w_func)
          2'b00: w_op = OP_ADD;
          2'b01: begin
            w_op   = OP_ADD;
            w_inva = 1'b1;
            w_cin  = 1'b1;
          end
          2'b10: w_op = OP_XOR;
          default: begin
            w_op   = OP_AND;
            w_invb = 1'b1;
          end
        endcase
      end
      // Compares subtract B from A except SCO, which reads the raw carry-out
      5'b11100, 5'b11101, 5'b11110, 5'b11111: begin
        w_op   = OP_ADD;
        w_comp = 1'b1;
        w_cc   = CC_W'(w_opcode[1:0]);
        w_invb = (w_opcode[1:0] != 2'b11);
        w_cin  = (w_opcode[1:0] != 2'b11);
      end
      5'b11001: w_btr = 1'b1;
      5'b11000: begin
        w_pass = 1'b1;
        w_imm  = 1'b1;
      end
      5'b10010: begin
        w_slbi = 1'b1;
        w_imm  = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
    w_sign = (w_op == OP_ADD);
  end

  // Stage register: reset > flush > stall > capture/bubble
  always_ff @(posedge clk) begin
    if (rst || flush || (!stall && !in_valid)) begin
      out_valid <= 1'b0;
      Op        <= '0;
      Cin       <= 1'b0;
      invA      <= 1'b0;
      invB      <= 1'b0;
      sign      <= 1'b0;
      comp_cont <= '0;
      comp      <= 1'b0;
      pass      <= 1'b0;
      ex_BTR    <= 1'b0;
      ex_SLBI   <= 1'b0;
      imm_sel   <= 1'b0;
      illegal   <= 1'b0;
    end else if (!stall) begin
      out_valid <= 1'b1;
      Op        <= w_op;
      Cin       <= w_cin;
      invA      <= w_inva;
      invB      <= w_invb;
      sign      <= w_sign;
      comp_cont <= w_cc;
      comp      <= w_comp;
      pass      <= w_pass;
      ex_BTR    <= w_btr;
      ex_SLBI   <= w_slbi;
      imm_sel   <= w_imm;
      illegal   <= w_illegal;
    end
  end

endmodule
